pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
// Central stall/flush/halt sequencer for the 5-stage 16-bit pipeline. Watches decode,
// execute and memory status and drives write-enables and nop-injects for PC, IF/ID,
// ID/EX, EX/MEM and MEM/WB registers. Owns load-use stalls, taken-branch flushes,
// data-memory wait stalls and the halt drain sequence. Counts stall cycles for perf.
// PARAMETERS
// DRAIN_CYC  3   cycles after halt decode to let older instructions reach WB (1..7)
// CNT_W      16  width of stall_cnt perf counter
// PORTS
// clk            in   1      rising-edge clock
// rst            in   1      synchronous reset, active-high
// idex_memread   in   1      instruction in ID/EX is a load
// idex_dstreg    in   4      destination register of instruction in ID/EX
// ifid_srca      in   4      source A register of instruction in IF/ID
// ifid_srcb      in   4      source B register of instruction in IF/ID
// ifid_usea      in   1      IF/ID instruction reads srca
// ifid_useb      in   1      IF/ID instruction reads srcb
// branch_taken   in   1      branch resolved taken in ID this cycle
// dmem_busy      in   1      data memory cannot complete access this cycle
// halt_dec       in   1      IF/ID holds HLT opcode
// pc_we          out  1      PC register write enable
// ifid_we        out  1      IF/ID write enable
// ifid_nop       out  1      load nop into IF/ID (flush)
// idex_nop       out  1      load nop into ID/EX (bubble)
// exmem_we       out  1      EX/MEM write enable
// memwb_nop      out  1      load nop into MEM/WB
// halted         out  1      processor fully halted
// stall_cnt      out  CNT_W  saturating count of cycles with pc_we==0 while not halted
// BEHAVIOUR
// Reset: state=RUN, drain_cnt=0, stall_cnt=0; outputs take RUN-idle values:
//   pc_we=1, ifid_we=1, exmem_we=1, all nops=0, halted=0.
// All outputs combinational from state + inputs; state/counters update on posedge clk.
// States: RUN, LDUSE, MEMWAIT, DRAIN, HALTED.
// load_use = idex_memread & idex_dstreg!=0 &
//   ((ifid_usea & ifid_srca==idex_dstreg) | (ifid_useb & ifid_srcb==idex_dstreg)).
// RUN priority, highest first, evaluated same cycle:
//   1 dmem_busy: pc_we=ifid_we=exmem_we=0, memwb_nop=1, idex_nop=0 -> MEMWAIT.
//   2 load_use: pc_we=ifid_we=0, idex_nop=1 -> LDUSE (exactly one bubble).
//   3 branch_taken: ifid_nop=1 (squash fall-through fetch), pc_we=1 -> RUN.
//   4 halt_dec: pc_we=0, ifid_nop=1, drain_cnt<=DRAIN_CYC-1 -> DRAIN.
//   5 else all enables 1, nops 0, stay RUN.
// LDUSE: all enables 1, nops 0 -> RUN (hazard resolved by MEM->EX forwarding);
//   dmem_busy in LDUSE takes MEMWAIT path instead.
// MEMWAIT: while dmem_busy hold pipeline as rule 1; when dmem_busy==0 release
//   (all enables 1) -> RUN. Branch/load-use/halt inputs ignored while frozen;
//   they are re-evaluated in RUN from the held IF/ID contents.
// DRAIN: pc_we=0, ifid_nop=1, idex_nop=1 (no new work); EX/MEM,MEM/WB advance.
//   dmem_busy freezes as MEMWAIT outputs but stays in DRAIN, drain_cnt holds.
//   drain_cnt decrements per unfrozen cycle; at 0 -> HALTED.
// HALTED: pc_we=ifid_we=exmem_we=0, memwb_nop=1, halted=1; exit only via rst.
// stall_cnt: +1 each cycle pc_we==0 & state!=HALTED, saturates at all-ones.
// rst mid-sequence (any state) returns to RUN next edge; counters cleared.
// Register 0 never causes load-use stall. branch_taken with load_use: stall wins,
//   branch re-resolves after bubble.
// TESTING
// Load r3 then add r4,r3,r5 -> one cycle pc_we=0,idex_nop=1, then RUN; stall_cnt=1.
// Load r0 then use r0 -> no stall, pc_we stays 1.
// dmem_busy high 4 cycles in RUN -> pc_we=exmem_we=0,memwb_nop=1 for 4 cycles, RUN after.
// branch_taken & load_use same cycle -> LDUSE bubble first, ifid_nop=0 that cycle.
// halt_dec, DRAIN_CYC=3, no busy -> halted=1 on 4th cycle after; busy 2 cycles in DRAIN -> 6th.
// rst asserted in HALTED -> next cycle halted=0, pc_we=1, stall_cnt=0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/halt sequencer for the 5-stage pipeline: load-use bubbles, branch
// squashes, data-memory wait freezes, halt drain, and a saturating stall counter.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_RUN     | normal flow; hazards evaluated in priority order
// ST_LDUSE   | one bubble inserted last cycle; release, forwarding covers it
// ST_MEMWAIT | pipeline frozen on data-memory wait
// ST_DRAIN   | no new work; older instructions advance toward WB
// ST_HALTED  | everything frozen until reset
module pipeline_hazard_ctrl #(
  parameter int DRAIN_CYC = 3,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             idex_memread,
  input  logic [3:0]       idex_dstreg,
  input  logic [3:0]       ifid_srca,
  input  logic [3:0]       ifid_srcb,
  input  logic             ifid_usea,
  input  logic             ifid_useb,
  input  logic             branch_taken,
  input  logic             dmem_busy,
  input  logic             halt_dec,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_nop,
  output logic             idex_nop,
  output logic             exmem_we,
  output logic             memwb_nop,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [2:0] {
    ST_RUN,
    ST_LDUSE,
    ST_MEMWAIT,
    ST_DRAIN,
    ST_HALTED
  } state_t;

  localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYC - 1);

  state_t     state, state_nxt;
  logic [2:0] drain_cnt, drain_cnt_nxt;
  logic       load_use;

  assign load_use = idex_memread && (idex_dstreg != 4'd0) &&
                    ((ifid_usea && (ifid_srca == idex_dstreg)) ||
                     (ifid_useb && (ifid_srcb == idex_dstreg)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      drain_cnt <= 3'd0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
    end
  end

  always_comb begin
    pc_we         = 1'b1;
    ifid_we       = 1'b1;
    ifid_nop      = 1'b0;
    idex_nop      = 1'b0;
    exmem_we      = 1'b1;
    memwb_nop     = 1'b0;
    halted        = 1'b0;
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;

    case (state)
      ST_RUN: begin
        if (dmem_busy) begin
          pc_we     = 1'b0;
          ifid_we   = 1'b0;
          exmem_we  = 1'b0;
          memwb_nop = 1'b1;
          state_nxt = ST_MEMWAIT;
        end else if (load_use) begin
          pc_we     = 1'b0;
          ifid_we   = 1'b0;
          idex_nop  = 1'b1;
          state_nxt = ST_LDUSE;
        end else if (branch_taken) begin
          ifid_nop = 1'b1;
        end else if (halt_dec) begin
          pc_we         = 1'b0;
          ifid_nop      = 1'b1;
          drain_cnt_nxt = DRAIN_INIT;
          state_nxt     = ST_DRAIN;
        end
      end

      // Both release straight to RUN; hazards re-resolve from held IF/ID next cycle.
      ST_LDUSE, ST_MEMWAIT: begin
        if (dmem_busy) begin
          pc_we     = 1'b0;
          ifid_we   = 1'b0;
          exmem_we  = 1'b0;
          memwb_nop = 1'b1;
          state_nxt = ST_MEMWAIT;
        end else begin
          state_nxt = ST_RUN;
        end
      end

      // A memory wait freezes the drain in place; the count only moves when unfrozen.
      ST_DRAIN: begin
        if (dmem_busy) begin
          pc_we     = 1'b0;
          ifid_we   = 1'b0;
          exmem_we  = 1'b0;
          memwb_nop = 1'b1;
        end else begin
          pc_we    = 1'b0;
          ifid_nop = 1'b1;
          idex_nop = 1'b1;
          if (drain_cnt == 3'd0) begin
            state_nxt = ST_HALTED;
          end else begin
            drain_cnt_nxt = drain_cnt - 3'd1;
          end
        end
      end

      ST_HALTED: begin
        pc_we     = 1'b0;
        ifid_we   = 1'b0;
        exmem_we  = 1'b0;
        memwb_nop = 1'b1;
        halted    = 1'b1;
      end

      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (!pc_we && (state != ST_HALTED) && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
